// File: rtl/umai_aib_pkg.sv
// rtl/umai_aib_pkg.sv - shared widths and flit type for the AIB link model
package umai_aib_pkg;

  localparam int AibDataWidth   = 72;
  localparam int AibNumChannels = 6;

  typedef logic [AibDataWidth-1:0] aib_flit_t;

endpackage

// File: rtl/umai_aib_chn_buf.sv
// rtl/umai_aib_chn_buf.sv - one AIB channel: credits, flight pipeline, receive FIFO, optional HWM (UMAI_AIB_LINK_HWM_EN)
module umai_aib_chn_buf
  import umai_aib_pkg::*;
#(
  parameter int DataWidth = AibDataWidth,
  parameter int Depth     = 8,
  parameter int Latency   = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 link_en,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  input  logic [DataWidth-1:0] tx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic [DataWidth-1:0] rx_data
`ifdef UMAI_AIB_LINK_HWM_EN
  ,
  output logic [$clog2(Depth):0] hwm
`endif
);

  localparam int IdxW = $clog2(Depth);
  localparam int CntW = IdxW + 1;
  localparam logic [CntW-1:0] DepthCnt = CntW'(Depth);
  localparam logic [CntW-1:0] One      = CntW'(1);

  logic [CntW-1:0]      cred;
  logic                 accept;
  logic                 pop;
  logic                 wr_en;
  logic [DataWidth-1:0] wr_data;
  logic [CntW-1:0]      wptr;
  logic [CntW-1:0]      rptr;
  logic                 empty;
  logic                 full;
  logic [DataWidth-1:0] mem [Depth];

  // A credit stands for one free slot anywhere downstream (pipeline or FIFO),
  // so an accepted flit can always travel to the FIFO without stalling.
  assign tx_ready = link_en && (cred != '0) && !rst;
  assign accept   = tx_valid && tx_ready;
  assign pop      = rx_valid && rx_ready;

  // Credit counter: spend on accept, refund on pop, hold when both or neither
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cred <= DepthCnt;
    end else if (accept && !pop) begin
      cred <= cred - One;
    end else if (pop && !accept) begin
      cred <= cred + One;
    end
  end

  if (Latency == 1) begin : g_direct
    assign wr_en   = accept;
    assign wr_data = tx_data;
  end else begin : g_pipe
    logic                 pv [Latency-1];
    logic [DataWidth-1:0] pd [Latency-1];

    // Flight valid bits shift unconditionally; reset drops anything in flight
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        for (int i = 0; i < Latency - 1; i++) pv[i] <= 1'b0;
      end else begin
        pv[0] <= accept;
        for (int i = 1; i < Latency - 1; i++) pv[i] <= pv[i-1];
      end
    end

    // Flight payload follows the valid bits; qualified by them so no reset needed
    always_ff @(posedge clk) begin
      pd[0] <= tx_data;
      for (int i = 1; i < Latency - 1; i++) pd[i] <= pd[i-1];
    end

    assign wr_en   = pv[Latency-2];
    assign wr_data = pd[Latency-2];
  end

  assign empty = (wptr == rptr);
  assign full  = (wptr[IdxW-1:0] == rptr[IdxW-1:0]) && (wptr[IdxW] != rptr[IdxW]);

  // FIFO pointers with wrap bit; full cannot occur under credit control but is still guarded
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (wr_en && !full) wptr <= wptr + One;
      if (pop) rptr <= rptr + One;
    end
  end

  // FIFO storage, intentionally left unreset
  always_ff @(posedge clk) begin
    if (wr_en && !full) mem[wptr[IdxW-1:0]] <= wr_data;
  end

  assign rx_valid = !empty;
  assign rx_data  = empty ? '0 : mem[rptr[IdxW-1:0]];

`ifdef UMAI_AIB_LINK_HWM_EN
  logic [CntW-1:0] occ;
  assign occ = DepthCnt - cred;

  // High-water mark of consumed credits; occ can never exceed Depth
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hwm <= '0;
    end else if (occ > hwm) begin
      hwm <= occ;
    end
  end
`endif

endmodule

// File: rtl/umai_aib_link_fifo.sv
// rtl/umai_aib_link_fifo.sv - multi-channel AIB link model with per-channel elastic buffer (o_hwm with UMAI_AIB_LINK_HWM_EN)
module umai_aib_link_fifo
  import umai_aib_pkg::*;
#(
  parameter int NumChannels = AibNumChannels,
  parameter int DataWidth   = AibDataWidth,
  parameter int Depth       = 8,
  parameter int Latency     = 2
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_link_en,
  input  logic                 i_tx_valid [NumChannels],
  output logic                 o_tx_ready [NumChannels],
  input  logic [DataWidth-1:0] i_tx_data  [NumChannels],
  output logic                 o_rx_valid [NumChannels],
  input  logic                 i_rx_ready [NumChannels],
  output logic [DataWidth-1:0] o_rx_data  [NumChannels]
`ifdef UMAI_AIB_LINK_HWM_EN
  ,
  output logic [$clog2(Depth):0] o_hwm [NumChannels]
`endif
);

  for (genvar c = 0; c < NumChannels; c++) begin : g_chn
    umai_aib_chn_buf #(
      .DataWidth (DataWidth),
      .Depth     (Depth),
      .Latency   (Latency)
    ) u_buf (
      .clk      (i_clk),
      .rst      (i_rst),
      .link_en  (i_link_en),
      .tx_valid (i_tx_valid[c]),
      .tx_ready (o_tx_ready[c]),
      .tx_data  (i_tx_data[c]),
      .rx_valid (o_rx_valid[c]),
      .rx_ready (i_rx_ready[c]),
      .rx_data  (o_rx_data[c])
`ifdef UMAI_AIB_LINK_HWM_EN
      ,
      .hwm      (o_hwm[c])
`endif
    );
  end

endmodule

// File: doc/umai_aib_link_fifo.md
# umai_aib_link_fifo

Per-channel AIB link model and elastic buffer between a UMAI endpoint's TX channels (`o_tx_*` of `umai_slave`/`umai_master`) and the peer endpoint's RX channels (`i_rx_*`). It adds a fixed flight latency and a Depth-entry receive FIFO per channel. Credit-based flow control guarantees the in-flight pipeline never stalls. One instance per link direction in multi-chiplet models.

## Interface
- `NumChannels`, 6, number of AIB channels.
- `DataWidth`, 72, flit width per channel.
- `Depth`, 8, receive FIFO entries per channel; power of two, ≥2.
- `Latency`, 2, flight latency in cycles; ≥1.
- `i_clk` input 1: single clock; all logic on rising edge.
- `i_rst` input 1: asynchronous, active-high reset.
- `i_link_en` input 1: when low, no new flits are accepted.
- `i_tx_valid` input [NumChannels] (unpacked): flit valid per channel.
- `o_tx_ready` output [NumChannels]: flit accept per channel.
- `i_tx_data` input [NumChannels][DataWidth]: flit payload.
- `o_rx_valid` output [NumChannels]: FIFO head valid.
- `i_rx_ready` input [NumChannels]: consumer pop.
- `o_rx_data` output [NumChannels][DataWidth]: FIFO head payload.
- `o_hwm` output [NumChannels][$clog2(Depth)+1]: high-water mark; present only with the macro below.

## Operation
- Channels are fully independent; all rules below apply per channel.
- Credit counter `cred`, width $clog2(Depth)+1, resets to Depth.
- `o_tx_ready` = `i_link_en` && (`cred` != 0) && !`i_rst`.
- Accept = `i_tx_valid` && `o_tx_ready`. Pop = `o_rx_valid` && `i_rx_ready`.
- `cred` update:
  - −1 on accept only.
  - +1 on pop only.
  - Unchanged on both, or on neither.
- Invariant: `cred` + in-flight + occupancy == Depth; `cred` never underflows or exceeds Depth.
- Flight pipeline: Latency−1 register stages of {valid, data}. They shift every cycle and never stall. The last stage writes the FIFO; with Latency=1 the accepted flit writes the FIFO directly.
- FIFO pointers: `wptr`/`rptr`, $clog2(Depth)+1 bits with wrap bit.
  - Empty: pointers equal.
  - Full: index bits equal, wrap bits differ.
  - Full is unreachable given credits.
- Data path: `o_rx_valid` = !empty. `o_rx_data` = head entry when valid, else all-zero. FIFO storage is not reset.
- Link disable: deasserting `i_link_en` blocks new accepts only. In-flight flits still land in the FIFO and the RX side keeps draining.
- Reset mid-operation: in-flight and buffered flits are discarded, `cred` returns to Depth, pointers return to 0.
- `i_tx_valid` may drop without acceptance; no protocol check is performed.

## Timing
- Reset values:
  - `o_tx_ready`=0 while `i_rst` is high; after release it equals `i_link_en`.
  - `o_rx_valid`=0, `o_rx_data`=0.
  - `o_hwm`=0.
- Flit accepted in cycle t, FIFO empty: `o_rx_valid`=1 in cycle t+Latency.
- FIFO non-empty: FIFO order is preserved; the head shows in the cycle after the prior pop.
- Credit from a pop in cycle t raises `o_tx_ready` in cycle t+1. There is no combinational path from `i_rx_ready` to `o_tx_ready`.
- Sustained throughput is 1 flit/cycle per channel when consumer `i_rx_ready`=1 and Depth ≥ Latency+1.
- `o_rx_valid`/`o_rx_data` depend only on registers.

## Configuration
- `UMAI_AIB_LINK_HWM_EN` defined:
  - `o_hwm` exists.
  - Per channel it holds max(Depth−`cred`) since reset, updated one cycle after the occupancy change, saturating at Depth.
- Undefined: port and logic are absent; behaviour is otherwise identical.

## Structure
- Package `umai_aib_pkg`:
  - `AibDataWidth`=72.
  - typedef `aib_flit_t` = logic[AibDataWidth-1:0].
  - Default `NumChannels`=6.
- Sub-module `umai_aib_chn_buf` holds one channel (credits, flight pipeline, FIFO, optional HWM). The top generates NumChannels instances.

## Test plan
- Single flit, Latency=2, ch0 data 72'hA5 accepted in cycle 10 → `o_rx_valid[0]`=1 in cycle 12 with data A5; other channels stay idle.
- Backpressure: `i_rx_ready`=0, Depth=8, push continuously → exactly 8 accepts, then `o_tx_ready`=0. One pop → `o_tx_ready`=1 next cycle and exactly one more accept.
- Streaming: push and pop every cycle on all 6 channels with Latency=2, Depth=8, 1000 flits with incrementing data → in-order, lossless delivery at 1 flit/cycle.
- Simultaneous accept and pop with `cred`=1 → `cred` stays 1 and `o_tx_ready` stays high.
- Link disable: 3 flits in flight, then `i_link_en`=0 → all 3 delivered, no new accepts; re-enable → accepts resume.
- Reset mid-stream with 5 buffered flits → `o_rx_valid`=0 immediately. After release: `cred`=Depth, and with HWM enabled `o_hwm`=0.
